// File: rtl/spec_free_list_ctrl_pkg.sv
// Shared types for the speculative free-list controller: state encoding, default widths, popcount helper.
// No logic; no latency.
// No flow control.
package spec_free_list_ctrl_pkg;

    localparam int PHY_REG_NUM_DEF = 64;
    localparam int IW = $clog2(PHY_REG_NUM_DEF);
    localparam int CW = $clog2(PHY_REG_NUM_DEF + 1);

    typedef logic [IW-1:0] preg_idx_t;

    typedef enum logic [1:0] {
        FL_INIT    = 2'd0,
        FL_NORMAL  = 2'd1,
        FL_RECOVER = 2'd2
    } fl_state_e;

    function automatic int unsigned countones(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/spec_free_list_ctrl_ram.sv
// Free-list storage: async read ports for rename slots, synchronous write ports for init and frees.
// Read latency zero cycles, write visible after the next clock edge.
// No backpressure; callers guarantee distinct write addresses within a cycle.
module free_list_ram #(
    parameter int DEPTH    = 64,
    parameter int RD_PORTS = 4,
    parameter int WR_PORTS = 3,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic [RD_PORTS*AW-1:0] rd_addr,
    output logic [RD_PORTS*AW-1:0] rd_dat,
    input  logic [WR_PORTS-1:0]    wr_en,
    input  logic [WR_PORTS*AW-1:0] wr_addr,
    input  logic [WR_PORTS*AW-1:0] wr_dat
);

    logic [AW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int p = 0; p < WR_PORTS; p++) begin
            if (wr_en[p]) begin
                mem[wr_addr[p*AW +: AW]] <= wr_dat[p*AW +: AW];
            end
        end
    end

    always_comb begin
        rd_dat = '0;
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_dat[k*AW +: AW] = mem[rd_addr[k*AW +: AW]];
        end
    end

endmodule

// File: rtl/spec_free_list_ctrl.sv
// Speculative physical-register free list: all-or-nothing rename allocation, committed frees, flush restore.
// Allocation grant and register numbers are combinational; frees become allocatable one cycle later.
// Allocation stalls (ready low) on insufficient count, during init and for flush+recover; frees never stall.
module spec_free_list_ctrl
    import spec_free_list_ctrl_pkg::*;
#(
    parameter int PHY_REG_NUM  = PHY_REG_NUM_DEF,
    parameter int RENAME_WIDTH = 4,
    parameter int COMMIT_WIDTH = 2,
    localparam int IDX_W = $clog2(PHY_REG_NUM),
    localparam int CNT_W = $clog2(PHY_REG_NUM + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush_i,
    input  logic [IDX_W-1:0]                arch_head_i,
    input  logic [CNT_W-1:0]                arch_cnt_i,
    input  logic [RENAME_WIDTH-1:0]         alloc_req_i,
    output logic                            alloc_ready_o,
    output logic [RENAME_WIDTH*IDX_W-1:0]   alloc_preg_o,
    input  logic [COMMIT_WIDTH-1:0]         free_valid_i,
    input  logic [COMMIT_WIDTH*IDX_W-1:0]   free_preg_i,
    output logic [CNT_W-1:0]                spec_cnt_o,
    output logic                            init_done_o
);

    fl_state_e state_q, state_n;
    logic [IDX_W-1:0] head_q, head_n;
    logic [IDX_W-1:0] tail_q, tail_n;
    logic [IDX_W-1:0] init_ptr_q, init_ptr_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] free_cnt;
    logic [CNT_W-1:0] alloc_cnt;
    logic             fire;
    logic             init_we;

    logic [RENAME_WIDTH*IDX_W-1:0] rd_addr;
    logic [COMMIT_WIDTH*IDX_W-1:0] free_addr;
    logic [COMMIT_WIDTH-1:0]       free_we;

    assign req_cnt  = CNT_W'(countones(32'(alloc_req_i)));
    assign free_cnt = CNT_W'(countones(32'(free_valid_i)));

    // Only cnt_q gates the grant, so ready never depends on same-cycle frees.
    assign alloc_ready_o = (state_q == FL_NORMAL) && (cnt_q >= req_cnt) && !flush_i;
    assign fire          = alloc_ready_o && (|alloc_req_i);
    assign alloc_cnt     = fire ? req_cnt : '0;
    assign init_we       = (state_q == FL_INIT);
    assign free_we       = free_valid_i & {COMMIT_WIDTH{state_q != FL_INIT}};

    assign spec_cnt_o  = cnt_q;
    assign init_done_o = (state_q != FL_INIT);

    // Sparse requests and frees are prefix-compacted onto consecutive entries.
    always_comb begin
        logic [IDX_W-1:0] roff;
        logic [IDX_W-1:0] woff;
        roff      = '0;
        woff      = '0;
        rd_addr   = '0;
        free_addr = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            rd_addr[k*IDX_W +: IDX_W] = head_q + roff;
            roff = roff + IDX_W'(alloc_req_i[k]);
        end
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            free_addr[s*IDX_W +: IDX_W] = tail_q + woff;
            woff = woff + IDX_W'(free_valid_i[s]);
        end
    end

    always_comb begin
        state_n    = state_q;
        head_n     = head_q;
        tail_n     = tail_q;
        cnt_n      = cnt_q;
        init_ptr_n = init_ptr_q;
        unique case (state_q)
            FL_INIT: begin
                init_ptr_n = init_ptr_q + IDX_W'(1);
                if (init_ptr_q == IDX_W'(PHY_REG_NUM - 1)) begin
                    state_n = FL_NORMAL;
                    head_n  = '0;
                    tail_n  = '0;
                    cnt_n   = CNT_W'(PHY_REG_NUM);
                end
            end
            default: begin
                tail_n = tail_q + IDX_W'(free_cnt);
                if (flush_i) begin
                    // Architectural count already includes this cycle's frees.
                    state_n = FL_RECOVER;
                    head_n  = arch_head_i;
                    cnt_n   = arch_cnt_i;
                end else begin
                    state_n = FL_NORMAL;
                    head_n  = head_q + IDX_W'(alloc_cnt);
                    cnt_n   = cnt_q + free_cnt - alloc_cnt;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FL_INIT;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            init_ptr_q <= '0;
        end else begin
            state_q    <= state_n;
            head_q     <= head_n;
            tail_q     <= tail_n;
            cnt_q      <= cnt_n;
            init_ptr_q <= init_ptr_n;
        end
    end

    free_list_ram #(
        .DEPTH    (PHY_REG_NUM),
        .RD_PORTS (RENAME_WIDTH),
        .WR_PORTS (COMMIT_WIDTH + 1),
        .AW       (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rd_addr (rd_addr),
        .rd_dat  (alloc_preg_o),
        .wr_en   ({free_we, init_we}),
        .wr_addr ({free_addr, init_ptr_q}),
        .wr_dat  ({free_preg_i, init_ptr_q})
    );

    a_no_free_in_init: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == FL_INIT) |-> (free_valid_i == '0));

    a_cnt_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != FL_INIT && !flush_i) |->
        (({1'b0, cnt_q} + {1'b0, free_cnt}) <= ({1'b0, CNT_W'(PHY_REG_NUM)} + {1'b0, alloc_cnt})));

endmodule

// File: tb/tb_spec_free_list_ctrl.sv
// Bench for spec_free_list_ctrl: directed init/sparse/exhaustion/flush/reset plus random alloc/free traffic.
module tb_spec_free_list_ctrl;
    import spec_free_list_ctrl_pkg::*;

    localparam int N   = 64;
    localparam int RW  = 4;
    localparam int CWD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [5:0]  arch_head = '0;
    logic [6:0]  arch_cnt = '0;
    logic [3:0]  req = '0;
    logic        ready;
    logic [23:0] pregs;
    logic [1:0]  fv = '0;
    logic [11:0] fp = '0;
    logic [6:0]  scnt;
    logic        done;

    always #5 clk = ~clk;

    spec_free_list_ctrl #(.PHY_REG_NUM(N), .RENAME_WIDTH(RW), .COMMIT_WIDTH(CWD)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .arch_head_i   (arch_head),
        .arch_cnt_i    (arch_cnt),
        .alloc_req_i   (req),
        .alloc_ready_o (ready),
        .alloc_preg_o  (pregs),
        .free_valid_i  (fv),
        .free_preg_i   (fp),
        .spec_cnt_o    (scnt),
        .init_done_o   (done)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: free list as a plain array with head/tail/count, plus outstanding-register set.
    int mst = 0;  // 0 = init, 1 = normal, 2 = recover
    int mptr = 0, mhead = 0, mtail = 0, mcnt = 0;
    int mram [N];
    bit outst [N];
    int pool [$];
    bit uniq_en = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst = 0; mptr = 0; mhead = 0; mtail = 0; mcnt = 0;
            pool.delete();
            foreach (outst[i]) outst[i] = 1'b0;
        end else if (mst == 0) begin
            mram[mptr] = mptr;
            if (mptr == N - 1) begin
                mst = 1; mhead = 0; mtail = 0; mcnt = N;
            end
            mptr = (mptr + 1) % N;
        end else begin
            int rc, fc, j, p;
            bit ok;
            rc = $countones(req);
            fc = $countones(fv);
            ok = (mst == 1) && (mcnt >= rc) && !flush && (rc > 0);
            if (ok) begin
                for (int i = 0; i < rc; i++) begin
                    p = mram[(mhead + i) % N];
                    pool.push_back(p);
                    outst[p] = 1'b1;
                end
            end
            j = 0;
            for (int s = 0; s < CWD; s++) begin
                if (fv[s]) begin
                    p = int'(fp[s*6 +: 6]);
                    mram[(mtail + j) % N] = p;
                    outst[p] = 1'b0;
                    j++;
                end
            end
            mtail = (mtail + fc) % N;
            if (flush) begin
                mhead = int'(arch_head); mcnt = int'(arch_cnt); mst = 2;
            end else begin
                if (ok) begin
                    mhead = (mhead + rc) % N;
                    mcnt = mcnt - rc;
                end
                mcnt = mcnt + fc;
                mst = 1;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        begin
            int rc, off, nout;
            bit er;
            preg_idx_t p;
            rc = $countones(req);
            er = (mst == 1) && (mcnt >= rc) && !flush;
            chk("ready", int'(ready), int'(er));
            chk("spec_cnt", int'(scnt), mcnt);
            chk("init_done", int'(done), int'(mst != 0));
            if (er) begin
                off = 0;
                for (int k = 0; k < RW; k++) begin
                    if (req[k]) begin
                        p = pregs[k*6 +: 6];
                        chk("alloc_preg", int'(p), mram[(mhead + off) % N]);
                        if (uniq_en) chk("preg_unique", int'(outst[p]), 0);
                        off++;
                    end
                end
            end
            if (uniq_en && mst == 1) begin
                nout = 0;
                foreach (outst[i]) nout += int'(outst[i]);
                chk("cnt_vs_outstanding", int'(scnt), N - nout);
            end
        end
    end

    function automatic int pool_take();
        int idx, v;
        idx = $urandom_range(0, pool.size() - 1);
        v = pool[idx];
        pool.delete(idx);
        return v;
    endfunction

    function automatic void pool_remove(input int v);
        for (int i = 0; i < pool.size(); i++) begin
            if (pool[i] == v) begin
                pool.delete(i);
                return;
            end
        end
    endfunction

    task automatic wait_init();
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            #3;
            if (done) seen = 1'b1;
            else chk("init_ready_low", int'(ready), 0);
        end
        req = '0;
        chk("init_cycles", n, N);
        chk("init_cnt", int'(scnt), N);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_ready", int'(ready), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(scnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        wait_init();

        // Sparse allocation after init.
        @(negedge clk); req = 4'b1010; #3;
        chk("sparse_ready", int'(ready), 1);
        chk("sparse_slot1", int'(pregs[11:6]), 0);
        chk("sparse_slot3", int'(pregs[23:18]), 1);
        @(negedge clk); req = 4'b1111; #3;
        chk("full_slot0", int'(pregs[5:0]), 2);
        chk("full_slot1", int'(pregs[11:6]), 3);
        chk("full_slot2", int'(pregs[17:12]), 4);
        chk("full_slot3", int'(pregs[23:18]), 5);
        @(negedge clk); req = '0; #3;
        chk("cnt_58", int'(scnt), 58);

        // Drain to three entries, then a full request must stall.
        repeat (13) begin @(negedge clk); req = 4'b1111; end
        @(negedge clk); req = 4'b0111;
        @(negedge clk); req = 4'b1111; #3;
        chk("exh_cnt", int'(scnt), 3);
        chk("exh_ready", int'(ready), 0);
        @(negedge clk); pool_remove(7); fv = 2'b01; fp = {6'd0, 6'd7}; #3;
        chk("exh_free_ready", int'(ready), 0);
        @(negedge clk); fv = '0; fp = '0; #3;
        chk("wrap_ready", int'(ready), 1);
        chk("wrap_cnt", int'(scnt), 4);
        chk("wrap_slot0", int'(pregs[5:0]), 61);
        chk("wrap_slot3", int'(pregs[23:18]), 7);

        // Random traffic.
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            fv = '0;
            fp = '0;
            for (int s = 0; s < CWD; s++) begin
                if (pool.size() > 0 && $urandom_range(0, 3) != 0) begin
                    fv[s] = 1'b1;
                    fp[s*6 +: 6] = 6'(pool_take());
                end
            end
        end

        // Flush with two same-cycle frees.
        @(negedge clk);
        uniq_en = 1'b0;
        flush = 1'b1; arch_head = 6'd10; arch_cnt = 7'd40; req = 4'b1111;
        fv = '0; fp = '0;
        for (int s = 0; s < CWD; s++) begin
            if (pool.size() > 0) begin
                fv[s] = 1'b1;
                fp[s*6 +: 6] = 6'(pool_take());
            end
        end
        #3;
        chk("flush_ready", int'(ready), 0);
        @(negedge clk); flush = 1'b0; fv = '0; fp = '0; #3;
        chk("recover_ready", int'(ready), 0);
        chk("recover_cnt", int'(scnt), 40);
        @(negedge clk); req = 4'b0001; #3;
        chk("post_flush_ready", int'(ready), 1);
        chk("post_flush_cnt", int'(scnt), 40);
        chk("post_flush_slot0", int'(pregs[5:0]), mram[10]);

        // Asynchronous reset in the middle of normal operation.
        @(negedge clk); req = '0; #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_cnt", int'(scnt), 0);
        repeat (2) @(negedge clk);
        uniq_en = 1'b1;
        rst_n = 1'b1;
        req = 4'b1111;
        wait_init();
        @(negedge clk); req = 4'b1111; #3;
        chk("reinit_slot0", int'(pregs[5:0]), 0);
        chk("reinit_slot1", int'(pregs[11:6]), 1);
        chk("reinit_slot2", int'(pregs[17:12]), 2);
        chk("reinit_slot3", int'(pregs[23:18]), 3);
        @(negedge clk); req = '0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
